wide_alu_seq: RTL



---
 rtl/wide_alu_seq_pkg.sv | 33 +++
 rtl/wide_alu_seq_alu.sv | 64 ++++++
 rtl/wide_alu_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/wide_alu_seq_pkg.sv
// Shared definitions for wide_alu_seq: FSM states, wide opcodes and the
// opcode encoding of the 8-bit byte ALU.
package wide_alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_FIN    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    WOP_ADD = 3'd0,
    WOP_SUB = 3'd1,
    WOP_SHL = 3'd2,
    WOP_SHR = 3'd3,
    WOP_CEQ = 3'd4
  } wop_e;

  localparam logic [2:0] ALU_OP_NOP      = 3'd0;
  localparam logic [2:0] ALU_OP_ADD      = 3'd1;
  localparam logic [2:0] ALU_OP_SUB      = 3'd2;
  localparam logic [2:0] ALU_OP_CEQ      = 3'd3;
  localparam logic [2:0] ALU_FN_SHIFTL_X = 3'd4;
  localparam logic [2:0] ALU_FN_SHIFTL_O = 3'd5;
  localparam logic [2:0] ALU_FN_SHIFTR_X = 3'd6;
  localparam logic [2:0] ALU_FN_SHIFTR_O = 3'd7;

  function automatic logic wop_is_legal(input logic [2:0] w);
    return (w <= 3'(WOP_CEQ));
  endfunction

endpackage

// File: rtl/wide_alu_seq_alu.sv
// 8-bit byte ALU. The _X shifts shift in zero; the _O shifts shift in the
// overflow input so that two byte passes form one wide shift.
module wide_alu_seq_alu
  import wide_alu_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ovf_in,
  input  logic       flag_in,
  output logic [7:0] res,
  output logic       ovf_out,
  output logic       flag_out,
  output logic       br_en
);

  logic [8:0] sum_s;

  // Byte-wide datapath; overflow is carry for ADD and borrow for SUB.
  always_comb begin
    sum_s    = 9'h000;
    res      = 8'h00;
    ovf_out  = 1'b0;
    flag_out = 1'b0;
    case (op)
      ALU_OP_ADD: begin
        sum_s   = {1'b0, a} + {1'b0, b} + {8'h00, ovf_in};
        res     = sum_s[7:0];
        ovf_out = sum_s[8];
      end
      ALU_OP_SUB: begin
        sum_s   = {1'b0, a} - {1'b0, b} - {8'h00, ovf_in};
        res     = sum_s[7:0];
        ovf_out = sum_s[8];
      end
      ALU_OP_CEQ: begin
        flag_out = (a == b);
      end
      ALU_FN_SHIFTL_X: begin
        res     = {a[6:0], 1'b0};
        ovf_out = a[7];
      end
      ALU_FN_SHIFTL_O: begin
        res     = {a[6:0], ovf_in};
        ovf_out = a[7];
      end
      ALU_FN_SHIFTR_X: begin
        res     = {1'b0, a[7:1]};
        ovf_out = a[0];
      end
      ALU_FN_SHIFTR_O: begin
        res     = {ovf_in, a[7:1]};
        ovf_out = a[0];
      end
      default: begin
        res      = 8'h00;
        ovf_out  = 1'b0;
        flag_out = 1'b0;
      end
    endcase
    br_en = flag_out | flag_in;
  end

endmodule

// File: rtl/wide_alu_seq.sv
// 16-bit sequential ALU: each operation runs as two passes through one 8-bit
// byte ALU, chaining the overflow between passes.
module wide_alu_seq
  import wide_alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  wop,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry_out,
  output logic        flag_out,
  output logic        err
);

  state_e      state_q, state_d;
  logic [2:0]  wop_q, wop_d;
  logic [15:0] opa_q, opa_d;
  logic [15:0] opb_q, opb_d;
  logic        cy_q, cy_d;
  logic [7:0]  lo_res_q, lo_res_d;
  logic        lo_flag_q, lo_flag_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic        carry_out_q, carry_out_d;
  logic        flag_out_q, flag_out_d;
  logic        err_q, err_d;

  logic        sel_hi_s;
  logic [2:0]  alu_op_s;
  logic [7:0]  alu_a_s, alu_b_s, alu_res_s;
  logic        alu_ovf_in_s, alu_ovf_out_s, alu_flag_s;
  logic        alu_br_unused_s;
  logic        sub_borrow_s;

  // Byte selection and ALU opcode for the current pass; SHR walks high byte first.
  always_comb begin
    sel_hi_s     = (state_q == ST_SECOND) ^ (wop_q == WOP_SHR);
    alu_a_s      = sel_hi_s ? opa_q[15:8] : opa_q[7:0];
    alu_b_s      = sel_hi_s ? opb_q[15:8] : opb_q[7:0];
    alu_ovf_in_s = (state_q == ST_SECOND) ? cy_q : 1'b0;
    alu_op_s     = ALU_OP_NOP;
    if (((state_q == ST_FIRST) || (state_q == ST_SECOND)) && wop_is_legal(wop_q)) begin
      case (wop_q)
        WOP_ADD: alu_op_s = ALU_OP_ADD;
        WOP_SUB: alu_op_s = ALU_OP_SUB;
        WOP_CEQ: alu_op_s = ALU_OP_CEQ;
        WOP_SHL: alu_op_s = (state_q == ST_FIRST) ? ALU_FN_SHIFTL_X : ALU_FN_SHIFTL_O;
        WOP_SHR: alu_op_s = (state_q == ST_FIRST) ? ALU_FN_SHIFTR_X : ALU_FN_SHIFTR_O;
        default: alu_op_s = ALU_OP_NOP;
      endcase
    end else begin
      alu_op_s = ALU_OP_NOP;
    end
  end

  // Wide borrow from the operand high bytes plus the registered low-byte borrow.
  always_comb begin
    sub_borrow_s = (opa_q[15:8] < opb_q[15:8]) ||
                   ((opa_q[15:8] == opb_q[15:8]) && cy_q);
  end

  wide_alu_seq_alu u_alu (
    .op       (alu_op_s),
    .a        (alu_a_s),
    .b        (alu_b_s),
    .ovf_in   (alu_ovf_in_s),
    .flag_in  (1'b0),
    .res      (alu_res_s),
    .ovf_out  (alu_ovf_out_s),
    .flag_out (alu_flag_s),
    .br_en    (alu_br_unused_s)
  );

  // Sequencer next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    wop_d       = wop_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cy_d        = cy_q;
    lo_res_d    = lo_res_q;
    lo_flag_d   = lo_flag_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    flag_out_d  = flag_out_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          wop_d   = wop;
          opa_d   = opa;
          opb_d   = opb;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_FIRST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FIRST: begin
        cy_d      = alu_ovf_out_s;
        lo_res_d  = alu_res_s;
        lo_flag_d = alu_flag_s;
        busy_d    = 1'b1;
        state_d   = ST_SECOND;
      end
      ST_SECOND: begin
        done_d      = 1'b1;
        state_d     = ST_FIN;
        result_d    = 16'h0000;
        carry_out_d = 1'b0;
        flag_out_d  = 1'b0;
        err_d       = 1'b0;
        case (wop_q)
          WOP_ADD, WOP_SHL: begin
            result_d    = {alu_res_s, lo_res_q};
            carry_out_d = alu_ovf_out_s;
          end
          WOP_SUB: begin
            result_d    = {alu_res_s, lo_res_q};
            carry_out_d = sub_borrow_s;
          end
          WOP_SHR: begin
            result_d    = {lo_res_q, alu_res_s};
            carry_out_d = alu_ovf_out_s;
          end
          WOP_CEQ: begin
            flag_out_d = lo_flag_q & alu_flag_s;
          end
          default: begin
            err_d = 1'b1;
          end
        endcase
        cy_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wop_q       <= 3'd0;
      opa_q       <= 16'h0000;
      opb_q       <= 16'h0000;
      cy_q        <= 1'b0;
      lo_res_q    <= 8'h00;
      lo_flag_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 16'h0000;
      carry_out_q <= 1'b0;
      flag_out_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wop_q       <= wop_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cy_q        <= cy_d;
      lo_res_q    <= lo_res_d;
      lo_flag_q   <= lo_flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      flag_out_q  <= flag_out_d;
      err_q       <= err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign flag_out  = flag_out_q;
  assign err       = err_q;

endmodule
